// File: rtl/fall_edge_event_arbiter_pkg.sv
// Shared types and the round-robin search helper for the falling-edge event arbiter.
package edge_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  localparam int N_DEFAULT = 4;
  localparam int N_MAX     = 16;
  localparam int IDX_W     = 4;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] index;
  } rr_result_t;

  // First set bit of pend at or after ptr, wrapping modulo n (n <= N_MAX).
  function automatic rr_result_t rr_search(input logic [N_MAX-1:0] pend,
                                           input logic [IDX_W-1:0] ptr,
                                           input int n);
    rr_result_t res;
    logic [IDX_W:0] idx;
    res.found = 1'b0;
    res.index = '0;
    for (int off = 0; off < N_MAX; off++) begin
      idx = {1'b0, ptr} + 5'(off);
      idx = (idx >= 5'(n)) ? idx - 5'(n) : idx;
      if ((off < n) && !res.found && pend[idx[IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.index = idx[IDX_W-1:0];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fall_edge_event_arbiter_if.sv
// Valid/ready event channel between the arbiter (master) and its consumer (slave).
interface fall_edge_event_arbiter_if #(
  parameter int IDW = 2
);
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic           evt_ready;

  modport master (output evt_valid, output evt_id, input evt_ready);
  modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/fall_edge_event_arbiter_cell.sv
// Single-channel registered falling-edge detector with enable.
module fall_edge_cell (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic en,
  output logic fall
);
  logic d_q_r;

  // Previous-cycle sample of the line; resets low so no edge follows reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_q_r <= 1'b0;
    end else begin
      d_q_r <= d;
    end
  end

  assign fall = d_q_r & ~d & en;
endmodule

// File: rtl/fall_edge_event_arbiter.sv
// Latches per-line falling edges and offers them one at a time, round-robin,
// over a valid/ready channel.
module fall_edge_event_arbiter
  import edge_arb_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int IDW = $clog2(N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             D,
  input  logic [N-1:0]             en,
  fall_edge_event_arbiter_if.master evt,
  output logic [N-1:0]             pending,
  output logic [N-1:0]             overflow,
  input  logic                     ovf_clr
);
  state_t           state_r, state_n_s;
  logic [N-1:0]     pending_r, pending_n_s, overflow_r, overflow_n_s;
  logic [N-1:0]     fall_s, clr_mask_s;
  logic [IDW-1:0]   ptr_r, ptr_n_s, id_r, id_n_s, win_s;
  logic             valid_r, valid_n_s, load_s;
  logic [N_MAX-1:0] pend_ext_s;
  logic [IDX_W-1:0] ptr_ext_s;
  rr_result_t       rr_s;

  for (genvar i = 0; i < N; i++) begin : g_cell
    fall_edge_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .d    (D[i]),
      .en   (en[i]),
      .fall (fall_s[i])
    );
  end

  // Round-robin winner among currently latched events.
  always_comb begin
    pend_ext_s             = '0;
    pend_ext_s[N-1:0]      = pending_r;
    ptr_ext_s              = '0;
    ptr_ext_s[IDW-1:0]     = ptr_r;
    rr_s                   = rr_search(pend_ext_s, ptr_ext_s, N);
    win_s                  = IDW'(rr_s.index);
  end

  // Offer FSM: loads a winner when idle or on handshake, so events stream without bubbles.
  always_comb begin
    state_n_s = state_r;
    valid_n_s = valid_r;
    id_n_s    = id_r;
    load_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rr_s.found) begin
          load_s    = 1'b1;
          state_n_s = ST_OFFER;
          valid_n_s = 1'b1;
          id_n_s    = win_s;
        end else begin
          valid_n_s = 1'b0;
        end
      end
      ST_OFFER: begin
        if (evt.evt_ready && rr_s.found) begin
          load_s = 1'b1;
          id_n_s = win_s;
        end else if (evt.evt_ready) begin
          state_n_s = ST_IDLE;
          valid_n_s = 1'b0;
        end else begin
          valid_n_s = 1'b1;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
        valid_n_s = 1'b0;
      end
    endcase
  end

  // Pending/overflow/pointer next state; a same-cycle edge beats the load clear.
  always_comb begin
    clr_mask_s = '0;
    if (load_s) begin
      clr_mask_s[win_s] = 1'b1;
      ptr_n_s = (win_s == IDW'(N - 1)) ? '0 : win_s + 1'b1;
    end else begin
      ptr_n_s = ptr_r;
    end
    pending_n_s  = (pending_r & ~clr_mask_s) | fall_s;
    overflow_n_s = (ovf_clr ? '0 : overflow_r) | (fall_s & pending_r & ~clr_mask_s);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      valid_r    <= 1'b0;
      id_r       <= '0;
      ptr_r      <= '0;
      pending_r  <= '0;
      overflow_r <= '0;
    end else begin
      state_r    <= state_n_s;
      valid_r    <= valid_n_s;
      id_r       <= id_n_s;
      ptr_r      <= ptr_n_s;
      pending_r  <= pending_n_s;
      overflow_r <= overflow_n_s;
    end
  end

  assign evt.evt_valid = valid_r;
  assign evt.evt_id    = id_r;
  assign pending       = pending_r;
  assign overflow      = overflow_r;
endmodule

// File: tb/tb_fall_edge_event_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_fall_edge_event_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] d, en, pending, overflow;
  logic         ovf_clr;

  fall_edge_event_arbiter_if #(.IDW(IDW)) evt_if ();

  fall_edge_event_arbiter #(.N(N), .IDW(IDW)) dut (
    .clk      (clk),
    .rst      (rst),
    .D        (d),
    .en       (en),
    .evt      (evt_if),
    .pending  (pending),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [N-1:0] m_dq, m_pend, m_ovf;
  logic         m_valid;
  int           m_id, m_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dq = '0; m_pend = '0; m_ovf = '0; m_valid = 1'b0; m_id = 0; m_ptr = 0;
  endtask

  task automatic model_tick();
    logic [N-1:0] fall, clr;
    bit found;
    int k;
    if (!rst) begin
      model_reset();
    end else begin
      fall  = m_dq & ~d & en;
      clr   = '0;
      found = 1'b0;
      k     = 0;
      if ((!m_valid || evt_if.evt_ready) && (m_pend != '0)) begin
        for (int o = 0; o < N; o++) begin
          if (!found && m_pend[(m_ptr + o) % N]) begin
            found = 1'b1;
            k = (m_ptr + o) % N;
          end
        end
      end
      if (found) begin
        m_valid = 1'b1;
        m_id    = k;
        m_ptr   = (k + 1) % N;
        clr[k]  = 1'b1;
      end else if (m_valid && evt_if.evt_ready) begin
        m_valid = 1'b0;
      end
      m_ovf  = (ovf_clr ? '0 : m_ovf) | (fall & m_pend & ~clr);
      m_pend = (m_pend & ~clr) | fall;
      m_dq   = d;
    end
  endtask

  task automatic compare_all();
    check("valid", evt_if.evt_valid, m_valid);
    if (m_valid) check("id", evt_if.evt_id, m_id);
    check("pending", pending, m_pend);
    check("overflow", overflow, m_ovf);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_tick();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    d = 4'hF; en = 4'hF; ovf_clr = 1'b0; evt_if.evt_ready = 1'b0;
    model_reset();
    #12;
    check("rst_valid", evt_if.evt_valid, 1'b0);
    check("rst_id", evt_if.evt_id, 2'd0);
    check("rst_pending", pending, 4'h0);
    check("rst_overflow", overflow, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    cycle(); cycle();

    // Simultaneous falls streamed back-to-back in order 0..3
    evt_if.evt_ready = 1'b1; d = 4'h0;
    cycle();
    check("simul_pend", pending, 4'hF);
    for (int k = 0; k < N; k++) begin
      cycle();
      check("simul_valid", evt_if.evt_valid, 1'b1);
      check("simul_id", evt_if.evt_id, k);
    end
    cycle();
    check("simul_idle", evt_if.evt_valid, 1'b0);
    d = 4'hF; evt_if.evt_ready = 1'b0;
    cycle();

    // Single edge on channel 2
    d = 4'hB;
    cycle();
    check("single_pend", pending, 4'b0100);
    check("single_nov", evt_if.evt_valid, 1'b0);
    cycle();
    check("single_valid", evt_if.evt_valid, 1'b1);
    check("single_id", evt_if.evt_id, 2'd2);
    check("single_pend0", pending, 4'h0);
    evt_if.evt_ready = 1'b1;
    cycle();
    check("single_done", evt_if.evt_valid, 1'b0);
    evt_if.evt_ready = 1'b0; d = 4'hF;
    cycle();

    // Fairness: after channel 1, channels 0 and 3 pending -> 3 then 0
    d = 4'hD; cycle();
    d = 4'hF; cycle();
    check("rr_first", evt_if.evt_id, 2'd1);
    d = 4'h6; cycle();
    d = 4'hF; evt_if.evt_ready = 1'b1;
    cycle();
    check("rr_id3", evt_if.evt_id, 2'd3);
    cycle();
    check("rr_id0", evt_if.evt_id, 2'd0);
    cycle();
    evt_if.evt_ready = 1'b0;

    // Backpressure, overflow and its clear
    d = 4'hB; cycle();
    d = 4'hF; cycle();
    for (int c = 0; c < 5; c++) begin
      d = (c == 0 || c == 2) ? 4'hE : 4'hF;
      cycle();
      check("bp_valid", evt_if.evt_valid, 1'b1);
      check("bp_id", evt_if.evt_id, 2'd2);
      if (c == 2) check("bp_ovf", overflow, 4'b0001);
    end
    ovf_clr = 1'b1; cycle();
    check("ovf_clr", overflow, 4'h0);
    ovf_clr = 1'b0; evt_if.evt_ready = 1'b1;
    cycle(); cycle(); cycle();
    evt_if.evt_ready = 1'b0;

    // Set wins over load clear on the same channel
    d = 4'hE; cycle();
    d = 4'hF; cycle();
    d = 4'h7; cycle();
    d = 4'hF; cycle();
    d = 4'h7; evt_if.evt_ready = 1'b1;
    cycle();
    check("setwin_id", evt_if.evt_id, 2'd3);
    check("setwin_pend", pending, 4'b1000);
    check("setwin_ovf", overflow, 4'h0);
    d = 4'hF; cycle(); cycle(); cycle();
    evt_if.evt_ready = 1'b0;

    // Disabled channel ignores its edge
    en = 4'hD; d = 4'hD; cycle();
    check("en_pend", pending, 4'h0);
    cycle();
    check("en_valid", evt_if.evt_valid, 1'b0);
    en = 4'hF; d = 4'hF; cycle();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      d = 4'($urandom);
      en = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      evt_if.evt_ready = ($urandom_range(0, 9) < 6);
      ovf_clr = ($urandom_range(0, 9) == 0);
      cycle();
    end

    // Asynchronous reset while offering
    en = 4'hF; ovf_clr = 1'b0; evt_if.evt_ready = 1'b0; d = 4'hF;
    cycle();
    d = 4'hE; cycle();
    d = 4'hF; cycle();
    check("pre_rst_valid", evt_if.evt_valid, 1'b1);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check("arst_valid", evt_if.evt_valid, 1'b0);
    check("arst_id", evt_if.evt_id, 2'd0);
    check("arst_pending", pending, 4'h0);
    check("arst_overflow", overflow, 4'h0);
    cycle();
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cycle();
      check("post_rst_idle", evt_if.evt_valid, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fall_edge_event_arbiter.md
# fall_edge_event_arbiter

- Monitors N independent input lines.
- Detects a falling edge on each enabled line and latches it as a pending event.
- Hands the pending events one at a time, in round-robin order, to a single downstream consumer over a valid/ready port.
- Sits between raw synchronous status lines and the event-servicing logic, so many falling-edge sources share one event channel without losing events.

## Interface
- N, 4: number of monitored lines (2..16).
- IDW, $clog2(N): width of the event id.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- D  in  N  monitored lines; already synchronous to clk.
- en  in  N  per-channel enable. A disabled channel ignores new edges, but its existing pending event is still arbitrated.
- evt_valid  out  1  an event is offered.
- evt_id  out  IDW  channel index of the offered event.
- evt_ready  in  1  consumer accepts the event.
- pending  out  N  latched, not-yet-offered events.
- overflow  out  N  sticky: an edge arrived while that channel was already pending.
- ovf_clr  in  1  clears all overflow bits.

## Operation
- Edge detection, per channel i:
  - D_q[i] registers D[i].
  - fall[i] = D_q[i] & ~D[i] & en[i].
- Pending update:
  - pending[i] is set on fall[i].
  - pending[i] is cleared when channel i is loaded into the offer register.
  - Set and clear in the same cycle: set wins. pending stays 1 and overflow does not set.
- Overflow:
  - overflow[i] is set when fall[i] occurs, pending[i]=1, and i is not being loaded that cycle.
  - ovf_clr clears all bits. If a set coincides with ovf_clr, the set wins.
- FSM, two states:
  - IDLE: evt_valid=0. If pending is nonzero, load the winner into evt_id, clear its pending bit, and go to OFFER.
  - OFFER: evt_valid=1; evt_id is held stable until the handshake (evt_valid & evt_ready).
  - On handshake with pending nonzero: load the next winner in the same cycle and stay in OFFER (back-to-back events, no bubble).
  - On handshake with pending zero: go to IDLE.
- Round-robin arbitration:
  - A pointer ptr names the highest-priority channel.
  - Search order is ptr, ptr+1, …, wrapping modulo N.
  - On each load of channel k, ptr <= (k+1) mod N.
- An edge on the channel currently offered sets pending normally; it is not an overflow.
- Dropping evt_valid without a handshake is not allowed.

## Timing
- Reset values, asynchronous on rst=0: D_q=0, pending=0, overflow=0, evt_valid=0, evt_id=0, ptr=0, state=IDLE.
  - Because D_q resets to 0, a line that is low or high out of reset produces no spurious edge.
- Reset mid-operation discards the offered event and all pending and overflow state.
- Latency:
  - D falls before posedge k (D_q=1, D=0 sampled at k): pending set after posedge k.
  - evt_valid=1 with evt_id after posedge k+1.
- Throughput: one event per cycle while evt_ready=1 and events are pending.
- evt_ready may be high before evt_valid; no combinational path from evt_ready to evt_valid.
- ovf_clr and en take effect on the next clock edge.

## Structure
- Package edge_arb_pkg:
  - FSM state enum (ST_IDLE, ST_OFFER).
  - Default N.
  - Round-robin search function (pending, ptr) -> {found, index}.
- Sub-module fall_edge_cell, instantiated N times:
  - Contains the single-channel registered falling detector with enable.
  - Output is fall[i].
- The top level holds pending, overflow, ptr, the FSM and the offer register.

## Test plan
- Single edge, N=4: after reset, en=4'hF, D=4'hF, then D[2] falls.
  - pending=4'b0100 after one edge.
  - Next cycle: evt_valid=1, evt_id=2, pending=0.
  - evt_ready=1 then gives evt_valid=0.
- Simultaneous edges: D falls 4'hF→4'h0 in one cycle with evt_ready held 1.
  - Events offered back-to-back in the order 0,1,2,3, with no idle cycle between them.
- Round-robin fairness:
  - After channel 1 is served, channels 0 and 3 both pending: channel 3 is offered first, then 0.
- Backpressure: hold evt_ready=0 for 5 cycles.
  - evt_id stays stable throughout.
  - A second edge on an already-pending channel sets overflow for that channel.
  - ovf_clr=1 returns overflow to 0.
- Enable and set-wins:
  - en[1]=0: a fall on D[1] is ignored.
  - A fall on channel k in the same cycle k is loaded: pending[k] stays 1 and overflow[k]=0.
- Reset mid-offer: rst=0 while evt_valid=1.
  - All outputs are 0 immediately, before the next clock edge.
  - After release, D held high produces no event.
